// File: rtl/uart_tx_module.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// Bit timing comes from an internal counter of CLK_FREQ/BAUD sysclk cycles per bit.
module uart_tx_module #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic       tx_en_sig,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done_sig
);

  localparam int               BIT_CNT   = CLK_FREQ / BAUD;
  localparam int               CNT_W     = (BIT_CNT > 1) ? $clog2(BIT_CNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BIT_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE   = CNT_W'(BIT_CNT - 2);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic             PAR_EN    = (PARITY_EN != 0);
  localparam logic             PAR_ODD   = (PARITY_ODD != 0);

  if (BIT_CNT < 2) begin : g_bad_bit_cnt
    $error("uart_tx_module: CLK_FREQ/BAUD must be at least 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_module: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e           state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [2:0]       idx_q,    idx_d;
  logic [7:0]       shift_q,  shift_d;
  logic             parity_q, parity_d;
  logic             tx_q,     tx_d;
  logic             done_q,   done_d;
  logic             bit_last;

  assign bit_last = (cnt_q == CNT_LAST);

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    tx_d     = tx_q;
    done_d   = 1'b0;

    if (state_q != S_IDLE) begin
      cnt_d = bit_last ? '0 : cnt_q + CNT_W'(1);
    end

    // tx_d is the level for the next cycle, so each bit appears the cycle after its transition.
    unique case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (tx_en_sig) begin
          shift_d  = tx_data;
          parity_d = (^tx_data) ^ PAR_ODD;
          cnt_d    = '0;
          idx_d    = '0;
          tx_d     = 1'b0;
          state_d  = S_START;
        end
      end
      S_START: begin
        if (bit_last) begin
          tx_d    = shift_q[0];
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_last) begin
          if (idx_q == 3'd7) begin
            idx_d = '0;
            if (PAR_EN) begin
              tx_d    = parity_q;
              state_d = S_PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = S_STOP;
            end
          end else begin
            idx_d   = idx_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end
      end
      S_PARITY: begin
        if (bit_last) begin
          tx_d    = 1'b1;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        tx_d = 1'b1;
        // Registered pulse: raised one cycle ahead so it lands on the final stop-bit cycle.
        if (cnt_q == CNT_PRE && idx_q == STOP_LAST) begin
          done_d = 1'b1;
        end
        if (bit_last) begin
          if (idx_q == STOP_LAST) begin
            idx_d   = '0;
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
      done_q   <= done_d;
    end
  end

  assign tx          = tx_q;
  assign tx_done_sig = done_q;
  assign tx_busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_module.sv
// Bench for uart_tx_module: four configurations share one stimulus stream; a per-instance
// monitor decodes each frame cycle by cycle against bytes queued when the request is driven.
module tb_uart_tx_module;

  logic       sysclk = 1'b0;
  logic       rst_n;
  logic       tx_en_sig;
  logic [7:0] tx_data;
  logic [3:0] tx_w;
  logic [3:0] busy_w;
  logic [3:0] done_w;
  wire  [31:0] ptr_w    [4];
  wire  [31:0] frames_w [4];
  wire  [31:0] dones_w  [4];

  int         checks = 0;
  int         errors = 0;
  int         cyc    = 0;
  bit         b2b_mode = 1'b0;
  logic [7:0] exp_q[$];

  always #5 sysclk = ~sysclk;
  always @(posedge sysclk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Config 0: 8N1 (10 bits), 1: even parity, 2: odd parity, 3: two stop bits (11 bits).
  for (genvar g = 0; g < 4; g++) begin : g_cfg
    localparam int PE = (g == 1 || g == 2) ? 1 : 0;
    localparam int PO = (g == 2) ? 1 : 0;
    localparam int SB = (g == 3) ? 2 : 1;
    localparam int NB = 9 + PE + SB;

    uart_tx_module #(
      .CLK_FREQ  (1000),
      .BAUD      (100),
      .PARITY_EN (PE),
      .PARITY_ODD(PO),
      .STOP_BITS (SB)
    ) u_dut (
      .sysclk     (sysclk),
      .rst_n      (rst_n),
      .tx_en_sig  (tx_en_sig),
      .tx_data    (tx_data),
      .tx         (tx_w[g]),
      .tx_busy    (busy_w[g]),
      .tx_done_sig(done_w[g])
    );

    int rd_ptr     = 0;
    int frames     = 0;
    int dones      = 0;
    int last_start = 0;

    assign ptr_w[g]    = 32'(rd_ptr);
    assign frames_w[g] = 32'(frames);
    assign dones_w[g]  = 32'(dones);

    always @(negedge sysclk) begin
      if (done_w[g] === 1'b1) dones++;
    end

    initial begin : mon
      logic [7:0]  b;
      logic [11:0] bits;
      bit          aborted;
      bit          b2b_seen;
      b2b_seen = 1'b0;
      forever begin
        @(negedge sysclk);
        if (rst_n === 1'b1 && tx_w[g] === 1'b0) begin
          if (!b2b_mode) b2b_seen = 1'b0;
          if (b2b_seen) check($sformatf("c%0d_b2b_start_gap", g), 32'(cyc - last_start), 32'(NB * 10 + 1));
          b2b_seen   = b2b_mode;
          last_start = cyc;
          check($sformatf("c%0d_frame_expected", g), 32'(rd_ptr < exp_q.size()), 32'd1);
          b = (rd_ptr < exp_q.size()) ? exp_q[rd_ptr] : 8'h00;
          rd_ptr++;
          bits      = '1;
          bits[0]   = 1'b0;
          bits[8:1] = b;
          if (PE != 0) bits[9] = (^b) ^ (PO != 0);
          aborted = 1'b0;
          for (int j = 0; j < NB; j++) begin
            for (int c = 0; c < 10; c++) begin
              if (!aborted) begin
                if (j != 0 || c != 0) @(negedge sysclk);
                if (rst_n !== 1'b1) begin
                  aborted = 1'b1;
                end else begin
                  check($sformatf("c%0d_tx_bit%0d", g, j), 32'(tx_w[g]), 32'(bits[j]));
                  check($sformatf("c%0d_busy", g), 32'(busy_w[g]), 32'd1);
                  check($sformatf("c%0d_done", g), 32'(done_w[g]), 32'(j == NB - 1 && c == 9));
                end
              end
            end
          end
          if (!aborted) begin
            frames++;
            @(negedge sysclk);
            if (rst_n === 1'b1) check($sformatf("c%0d_end_idle", g), 32'({tx_w[g], busy_w[g], done_w[g]}), 32'b100);
          end
        end
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge sysclk);
      n++;
    end while (busy_w != 4'h0 && n < 400);
    check("idle_timeout", 32'(busy_w), 32'h0);
  endtask

  task automatic send(input logic [7:0] d);
    @(negedge sysclk);
    check("pre_line", 32'(tx_w), 32'hF);
    tx_data   = d;
    tx_en_sig = 1'b1;
    exp_q.push_back(d);
    @(negedge sysclk);
    tx_en_sig = 1'b0;
    check("start_tx", 32'(tx_w), 32'h0);
    check("start_busy", 32'(busy_w), 32'hF);
  endtask

  initial begin
    tx_en_sig = 1'b0;
    tx_data   = 8'h00;
    rst_n     = 1'b1;
    #1 rst_n  = 1'b0;
    repeat (3) @(negedge sysclk);
    check("rst_tx", 32'(tx_w), 32'hF);
    check("rst_busy", 32'(busy_w), 32'h0);
    check("rst_done", 32'(done_w), 32'h0);
    rst_n = 1'b1;

    repeat (500) begin
      @(negedge sysclk);
      check("idle_tx", 32'(tx_w), 32'hF);
      check("idle_busy", 32'(busy_w), 32'h0);
      check("idle_done", 32'(done_w), 32'h0);
    end

    send(8'h55); wait_idle();
    send(8'h07); wait_idle();
    send(8'hA3); wait_idle();

    // Request and new data during a frame must be ignored.
    send(8'h00);
    repeat (34) @(negedge sysclk);
    tx_data   = 8'hFF;
    tx_en_sig = 1'b1;
    @(negedge sysclk);
    tx_en_sig = 1'b0;
    wait_idle();

    // Request held high: exactly two frames fit before it drops.
    @(negedge sysclk);
    b2b_mode  = 1'b1;
    tx_data   = 8'hA3;
    tx_en_sig = 1'b1;
    exp_q.push_back(8'hA3);
    exp_q.push_back(8'hA3);
    repeat (150) @(negedge sysclk);
    tx_en_sig = 1'b0;
    wait_idle();
    b2b_mode = 1'b0;

    // Reset in the middle of a frame.
    send(8'h3C);
    repeat (45) @(negedge sysclk);
    @(posedge sysclk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_tx", 32'(tx_w), 32'hF);
    check("rst_async_busy", 32'(busy_w), 32'h0);
    check("rst_async_done", 32'(done_w), 32'h0);
    repeat (3) begin
      @(negedge sysclk);
      check("rst_hold_tx", 32'(tx_w), 32'hF);
      check("rst_hold_done", 32'(done_w), 32'h0);
    end
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge sysclk);
      check("post_rst_tx", 32'(tx_w), 32'hF);
      check("post_rst_busy", 32'(busy_w), 32'h0);
    end
    send(8'hC5); wait_idle();
    repeat (5) @(negedge sysclk);

    for (int i = 0; i < 4; i++) begin
      check($sformatf("c%0d_queue_drained", i), ptr_w[i], 32'(exp_q.size()));
      check($sformatf("c%0d_frames", i), frames_w[i], 32'd7);
      check($sformatf("c%0d_done_pulses", i), dones_w[i], 32'd7);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_tx_module.md
Name: uart_tx_module

Overview:
- Serial UART transmitter. Converts one 8-bit byte per request into an asynchronous frame: start bit, 8 data bits LSB first, optional parity bit, 1 or 2 stop bits.
- Companion to the existing UART receive path and uses the same sysclk/rst_n domain.
- Contains its own bit-period counter, so no external baud clock is needed.
- Sits between the application's byte source and the board TX pin.

Parameters:
- CLK_FREQ, 50000000, sysclk frequency in Hz.
- BAUD, 115200, line rate in bit/s. BIT_CNT = CLK_FREQ/BAUD (integer truncation); legal only if BIT_CNT >= 2.
- PARITY_EN, 0, 1 inserts a parity bit after data bit 7.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- sysclk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- tx_en_sig  input  1  transmit request; sampled only while idle.
- tx_data  input  8  byte to send; captured in the accept cycle.
- tx  output  1  serial line; idle high.
- tx_busy  output  1  high while a frame is in progress.
- tx_done_sig  output  1  one-cycle pulse marking the end of a frame.

Behaviour:
- Reset: tx=1, tx_busy=0, tx_done_sig=0. State=IDLE, bit counter=0, bit index=0, shift register=0. All outputs are registered, except tx_busy, which is decoded from state (state != IDLE).
- N = 1 + 8 + PARITY_EN + STOP_BITS bits per frame. Every bit lasts exactly BIT_CNT cycles.
- States: IDLE, START, DATA, PARITY, STOP.
- Accept:
  - In IDLE with tx_en_sig=1 at edge T, the block latches tx_data into the shift register and computes the parity bit from the latched byte.
  - Parity bit = XOR of the 8 bits (even), or its inverse (odd).
  - State goes to START, bit counter clears.
- Timing relative to accept edge T:
  - tx=0 for cycles T+1 .. T+BIT_CNT.
  - Data bit i (i = 0..7) occupies cycles T+1+(i+1)*BIT_CNT .. T+(i+2)*BIT_CNT.
  - Parity bit (if enabled) follows bit 7.
  - Stop bits drive tx=1.
- Bit counter counts 0 .. BIT_CNT-1. At BIT_CNT-1 it wraps to 0 and advances the bit/state. The bit index wraps 7 -> 0 on leaving DATA.
- tx_done_sig is asserted for exactly one cycle: the final cycle of the last stop bit (cycle T+N*BIT_CNT). The next edge returns the block to IDLE, tx_busy=0.
- Back-to-back:
  - If tx_en_sig is high in the first IDLE cycle after done, a new frame is accepted there.
  - Minimum line-high time between frames is STOP_BITS*BIT_CNT+1 cycles.
  - No request is lost when tx_en_sig is held high continuously; frames repeat with tx_data re-sampled each accept.
- While busy:
  - tx_en_sig is ignored and not queued.
  - tx_data changes have no effect on the frame in flight.
- tx_done_sig never coincides with tx_busy=0 in the same cycle. tx_busy is still high during the done cycle.
- Reset mid-frame:
  - tx returns to 1 asynchronously, state goes to IDLE, no done pulse is issued.
  - After rst_n deasserts, the line stays high until a new accept.
- tx has no combinational path from any input; it is glitch-free.

Test Plan:
- Bench parameters CLK_FREQ=1000, BAUD=100 (BIT_CNT=10), PARITY_EN=0, STOP_BITS=1. tx_en_sig pulsed 1 cycle with tx_data=0x55 at edge T -> tx sequence 0,1,0,1,0,1,0,1,0,1, each level held 10 cycles. tx_done_sig high only at T+100. tx_busy high T+1..T+100.
- PARITY_EN=1, PARITY_ODD=0, tx_data=0x07 -> parity bit=1 on cycles T+91..T+100, stop bit T+101..T+110, done at T+110. Repeat with PARITY_ODD=1 -> parity bit=0.
- STOP_BITS=2, tx_data=0xA3 held with tx_en_sig high continuously -> frames of 110 cycles. Second start bit falls at T+112 (accepted at T+111). Exactly 21 high cycles between frames. Two done pulses at T+110 and T+221.
- tx_en_sig pulsed at T+35 with tx_data=0xFF during a 0x00 frame -> frame bits unaffected (all data 0), no second frame, single done pulse at T+100.
- rst_n low at T+47 for 3 cycles -> tx=1 in the same cycle (asynchronous), tx_busy=0, no tx_done_sig. A new request after release produces a complete correct frame.
- Idle after reset with tx_en_sig=0 for 500 cycles -> tx=1, tx_busy=0, tx_done_sig=0 throughout.
